// File: rtl/sb_pkg.sv
// Shared types and byte-lane helpers for the store buffer.
// Entry widths are fixed here; the module-level width parameters must match.
package sb_pkg;

  localparam int SB_ADDR_WIDTH = 32;
  localparam int SB_DATA_WIDTH = 32;
  localparam int BYTES         = SB_DATA_WIDTH / 8;
  localparam int OFS_BITS      = $clog2(BYTES);
  localparam int WADDR_WIDTH   = SB_ADDR_WIDTH - OFS_BITS;

  typedef struct packed {
    logic [WADDR_WIDTH-1:0]   waddr;
    logic [SB_DATA_WIDTH-1:0] data;
    logic [BYTES-1:0]         be;
  } sb_entry_t;

  function automatic logic [SB_DATA_WIDTH-1:0] be_to_mask(input logic [BYTES-1:0] be);
    logic [SB_DATA_WIDTH-1:0] mask;
    mask = '0;
    for (int b = 0; b < BYTES; b++) begin
      mask[8*b +: 8] = {8{be[b]}};
    end
    return mask;
  endfunction

  function automatic logic [SB_DATA_WIDTH-1:0] merge_bytes(
    input logic [SB_DATA_WIDTH-1:0] old_data,
    input logic [SB_DATA_WIDTH-1:0] new_data,
    input logic [BYTES-1:0]         be
  );
    logic [SB_DATA_WIDTH-1:0] mask;
    mask = be_to_mask(be);
    return (old_data & ~mask) | (new_data & mask);
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// CPU-side and memory-side signals of the store buffer, bundled as one interface.
interface store_buffer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wr_data;
  logic [BE_WIDTH-1:0]   cpu_wr_be;
  logic                  cpu_rd;
  logic                  cpu_wr;
  logic [DATA_WIDTH-1:0] cpu_rd_data;
  logic                  cpu_waitrequest;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_wr_mask;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  mem_waitrequest;
  logic                  sb_drain;
  logic                  sb_empty;

  modport slave (
    input  cpu_addr, cpu_wr_data, cpu_wr_be, cpu_rd, cpu_wr,
    input  mem_rd_data, mem_waitrequest, sb_drain,
    output cpu_rd_data, cpu_waitrequest,
    output mem_addr, mem_wr_data, mem_wr_mask, mem_rd, mem_wr, sb_empty
  );

  modport master (
    output cpu_addr, cpu_wr_data, cpu_wr_be, cpu_rd, cpu_wr,
    output mem_rd_data, mem_waitrequest, sb_drain,
    input  cpu_rd_data, cpu_waitrequest,
    input  mem_addr, mem_wr_data, mem_wr_mask, mem_rd, mem_wr, sb_empty
  );

endinterface

// File: rtl/store_buffer_fifo.sv
// Circular entry store with tail coalescing; exposes all entries oldest-first
// so the top level can overlay them onto load data.
module store_buffer_fifo
  import sb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  sb_entry_t        push_entry,
  input  logic             pop,
  output logic             coalesce,
  output logic [CNT_W-1:0] count,
  output sb_entry_t        age_entry [DEPTH],
  output logic [DEPTH-1:0] age_valid
);

  sb_entry_t        entry_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W-1:0] tail_last;
  logic             alloc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign tail_last = (tail_q == '0) ? PTR_W'(DEPTH - 1) : tail_q - 1'b1;

  // A lone entry that is leaving this cycle can no longer absorb bytes.
  assign coalesce = (count != '0)
                 && (entry_q[tail_last].waddr == push_entry.waddr)
                 && !(pop && (count == CNT_W'(1)));
  assign alloc    = push && !coalesce;

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      if (push && coalesce) begin
        entry_q[tail_last].data <= merge_bytes(entry_q[tail_last].data,
                                               push_entry.data, push_entry.be);
        entry_q[tail_last].be   <= entry_q[tail_last].be | push_entry.be;
      end else if (push) begin
        entry_q[tail_q] <= push_entry;
        tail_q          <= ptr_inc(tail_q);
      end
      if (pop) begin
        head_q <= ptr_inc(head_q);
      end
      count <= count + CNT_W'(alloc) - CNT_W'(pop);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_entry[i] = entry_q[PTR_W'((int'(head_q) + i) % DEPTH)];
      age_valid[i] = (i < int'(count));
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer in front of the single-port TCM: arbitrates the memory
// port between loads and drains and forwards buffered bytes into loads.
module store_buffer
  import sb_pkg::*;
#(
  parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
  parameter int DATA_WIDTH = SB_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input logic           clock,
  input logic           reset,
  store_buffer_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  sb_entry_t             age_entry [DEPTH];
  logic [DEPTH-1:0]      age_valid;
  logic [CNT_W-1:0]      count;
  sb_entry_t             push_entry;
  logic                  coalesce;
  logic                  has_data;
  logic                  full;
  logic                  drain;
  logic                  stall;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] fwd_data;

  assign push_entry = '{waddr: bus.cpu_addr[ADDR_WIDTH-1:OFS_BITS],
                        data:  bus.cpu_wr_data,
                        be:    bus.cpu_wr_be};

  assign has_data = (count != '0);
  assign full     = (count == CNT_W'(DEPTH));
  // Loads normally win the port; a full buffer or a fence hands it to the drain.
  assign drain    = has_data && (!bus.cpu_rd || full || bus.sb_drain);

  always_comb begin
    stall = 1'b0;
    if (bus.sb_drain)    stall = bus.cpu_rd || bus.cpu_wr;
    else if (bus.cpu_rd) stall = drain || bus.mem_waitrequest;
    else if (bus.cpu_wr) stall = full && !coalesce;
  end

  assign push = bus.cpu_wr && !stall;
  assign pop  = bus.mem_wr && !bus.mem_waitrequest;

  store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .coalesce   (coalesce),
    .count      (count),
    .age_entry  (age_entry),
    .age_valid  (age_valid)
  );

  // Oldest to youngest, so the youngest store to each byte lands last.
  always_comb begin
    fwd_data = bus.mem_rd_data;
    for (int i = 0; i < DEPTH; i++) begin
      if (age_valid[i] && (age_entry[i].waddr == push_entry.waddr)) begin
        fwd_data = merge_bytes(fwd_data, age_entry[i].data, age_entry[i].be);
      end
    end
  end

  assign bus.cpu_waitrequest = stall;
  assign bus.cpu_rd_data     = fwd_data;
  assign bus.mem_wr          = drain && !reset;
  assign bus.mem_rd          = bus.cpu_rd && !drain && !bus.sb_drain && !reset;
  assign bus.mem_addr        = drain ? {age_entry[0].waddr, {OFS_BITS{1'b0}}} : bus.cpu_addr;
  assign bus.mem_wr_data     = age_entry[0].data;
  assign bus.mem_wr_mask     = be_to_mask(age_entry[0].be);
  assign bus.sb_empty        = !has_data;

  a_rd_wr_exclusive: assert property (@(posedge clock) disable iff (reset)
    !(bus.cpu_rd && bus.cpu_wr));

  a_count_bound: assert property (@(posedge clock) disable iff (reset)
    count <= CNT_W'(DEPTH));

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the CPU memory stage and the single-port tightly-coupled memory.
- Accepts stores in one cycle without waiting for the memory port, and drains them in order when the port is idle.
- Merges consecutive same-word stores.
- Forwards buffered bytes into loads, so a load always sees the youngest store to each byte.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data width; multiple of 8
DEPTH, 4, buffer entries; DEPTH >= 2

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
cpu_addr  input  ADDR_WIDTH  byte address
cpu_wr_data  input  DATA_WIDTH  store data
cpu_wr_be  input  DATA_WIDTH/8  per-byte store enables
cpu_rd  input  1  load request
cpu_wr  input  1  store request
cpu_rd_data  output  DATA_WIDTH  load data, forwarded
cpu_waitrequest  output  1  stall the current request
mem_addr  output  ADDR_WIDTH  memory byte address
mem_wr_data  output  DATA_WIDTH  drain data
mem_wr_mask  output  DATA_WIDTH  bit-level write mask (byte enables expanded x8)
mem_rd  output  1  memory read
mem_wr  output  1  memory write
mem_rd_data  input  DATA_WIDTH  memory read data, combinational
mem_waitrequest  input  1  memory stall
sb_drain  input  1  fence request: block the CPU, drain to empty
sb_empty  output  1  buffer empty (count == 0)

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high.
- Reset state:
  - count = 0, head/tail pointers = 0, all entry state cleared.
  - Outputs: mem_rd = 0, mem_wr = 0, cpu_waitrequest = 0, sb_empty = 1.
  - Asserting reset mid-operation discards buffered stores. No memory write issues in the cycle after reset.
- Entry contents: {word address = addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)], data, be}. Circular FIFO with registered count.
- Store accept: when cpu_wr & ~cpu_waitrequest; takes effect at the clock edge. Zero latency to the CPU.
  - Coalesce when count > 0, the word address matches the tail entry, and the tail is not the head being popped this cycle.
  - Coalescing merges enabled bytes into the tail: new data replaces old per byte, be is ORed. Coalescing is allowed when full.
  - Otherwise allocate a new tail entry.
- Store stall: cpu_waitrequest = 1 for a store when count == DEPTH and the store cannot coalesce. A pop in the same cycle does not free the slot; the stall is computed from the registered count.
- Load:
  - mem_rd = 1, mem_addr = cpu_addr; mem_wr = 0 in that cycle.
  - cpu_waitrequest = mem_waitrequest.
  - cpu_rd_data = mem_rd_data with each byte overridden by the youngest valid entry whose word address matches and whose be bit is set.
- Drain:
  - Condition: count > 0 and (no cpu_rd, OR count == DEPTH, OR sb_drain).
  - Outputs: mem_wr = 1 with the head entry; mem_addr = word address << byte-offset bits.
  - Pop on mem_wr & ~mem_waitrequest.
  - A load that loses to a drain sees cpu_waitrequest = 1 and mem_rd = 0.
- Priority: load over drain, except when the buffer is full or sb_drain is set; then drain wins.
- sb_drain asserted: cpu_waitrequest = 1 for any request; the drain proceeds every cycle.
- Simultaneous accept and pop: count unchanged; pointers both advance.
- When cpu_rd = 0: cpu_rd_data is undefined.
- cpu_rd & cpu_wr together is illegal; enforce with a concurrent assertion.
- sb_empty is driven from the registered count.

Decomposition:
- Package sb_pkg holds:
  - BYTES = DATA_WIDTH/8 and OFS_BITS;
  - typedef sb_entry_t {word address, data, be};
  - function be_to_mask (byte enables -> bit mask);
  - function merge_bytes.
- Sub-module store_buffer_fifo: entry storage, pointers, count, coalesce-on-tail, and a parallel read of all entries for forwarding.
- The top level holds port arbitration, the forwarding overlay and the assertions.

Test Plan:
1. Store 0xDEADBEEF, be=4'hF, addr 0x100, with mem_waitrequest=1 -> sb_empty=0 and mem_wr held. Release the stall -> one write (addr 0x100, mask 0xFFFFFFFF) -> sb_empty=1 on the next cycle.
2. Store 0xAA, be=4'b0001, addr 0x200; load 0x200 on the next cycle with mem_rd_data=0x11223344 -> cpu_rd_data=0x112233AA and mem_wr=0 that cycle. The drain follows afterwards.
3. mem_waitrequest=1; store 0x0000BBBB be=4'b0011 to 0x300, then 0xCCCC0000 be=4'b1100 to 0x300 -> one entry, data 0xCCCCBBBB, be 4'hF.
4. DEPTH=4, mem_waitrequest=1; stores to 0x0, 0x4, 0x8, 0xC, 0x10 -> the fifth stalls. A load to 0x20 while full is stalled until the first drain pops.
5. Stores to A=0x40, B=0x44, A=0x40 (A's second store does not coalesce) -> three drains in order A, B, A. A load of A before draining returns the second A data.
6. Three entries buffered, assert reset for one cycle -> sb_empty=1, mem_wr=0, and no further writes.
